// File: rtl/ttt_pkg.sv
// Shared types and helpers for the tic-tac-toe match controller.
//   player_t : player encoding used on turn/eng_player/match_winner (3 = none)
//   state_t  : match controller FSM states
//   cell_idx : board cell number y*3+x for a legal (x,y) pair
package ttt_pkg;

   localparam int BOARD_N = 3;
   localparam int CELLS   = BOARD_N * BOARD_N;

   typedef enum logic [1:0] {
      P0    = 2'd0,
      P1    = 2'd1,
      PNONE = 2'd3
   } player_t;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CLEAR      = 3'd1,
      S_WAIT_MOVE  = 3'd2,
      S_ISSUE      = 3'd3,
      S_CHECK      = 3'd4,
      S_ROUND_END  = 3'd5,
      S_MATCH_DONE = 3'd6
   } state_t;

   function automatic logic [3:0] cell_idx(input logic [1:0] x, input logic [1:0] y);
      return ({2'b00, y} * 4'd3) + {2'b00, x};
   endfunction

endpackage

// File: rtl/ttt_move_timer.sv
// Per-move timeout timer.
//   clk, reset : clock and synchronous active-high reset
//   clr        : reload the timer for a fresh move window
//   en         : count one cycle of the move window
//   expired    : the current cycle is the last cycle of the window
// Down-counter loaded with TIMEOUT_CYCLES-1; expired is the terminal-count
// compare, so the window is exactly TIMEOUT_CYCLES enabled cycles long.
module ttt_move_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/ttt_match_ctrl.sv
// Match controller sequencing one tic-tac-toe engine between two players.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : pulse, begins a match from IDLE or MATCH_DONE
//   p0_*/p1_* req,x,y     : player move requests (held until ack/nack)
//   p0_*/p1_* ack,nack    : same-cycle accept/reject response to a request
//   eng_reset/enable/x/y/player : engine drive
//   eng_winner, eng_stop  : registered engine result
//   turn                  : player to move, 3 outside a round
//   score0, score1        : round wins
//   match_over, match_winner : match result
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | engine held in reset, waiting for start
// S_CLEAR      | one-cycle engine reset, shadow board and timer cleared
// S_WAIT_MOVE  | turn player may move; timer running
// S_ISSUE      | one-cycle engine enable with the accepted move
// S_CHECK      | engine result valid; round over or next turn
// S_ROUND_END  | score the round; next round or match done
// S_MATCH_DONE | result held, all requests rejected, waiting for start
module ttt_match_ctrl
   import ttt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int ROUNDS_TO_WIN  = 3,
   parameter int SCORE_W        = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               p0_req,
   input  logic [1:0]         p0_x,
   input  logic [1:0]         p0_y,
   input  logic               p1_req,
   input  logic [1:0]         p1_x,
   input  logic [1:0]         p1_y,
   output logic               p0_ack,
   output logic               p0_nack,
   output logic               p1_ack,
   output logic               p1_nack,
   output logic               eng_reset,
   output logic               eng_enable,
   output logic [1:0]         eng_x,
   output logic [1:0]         eng_y,
   output logic [1:0]         eng_player,
   input  logic [1:0]         eng_winner,
   input  logic               eng_stop,
   output logic [1:0]         turn,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1,
   output logic               match_over,
   output logic [1:0]         match_winner
);

   localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(ROUNDS_TO_WIN);

   state_t             state;
   player_t            turn_q;
   player_t            starter;
   player_t            round_winner;
   player_t            eng_player_q;
   player_t            match_winner_q;
   logic [CELLS-1:0]   board;
   logic [SCORE_W-1:0] score0_q;
   logic [SCORE_W-1:0] score1_q;

   logic               in_wait;
   logic               timer_clr;
   logic               expired;
   logic               sel_req;
   logic [1:0]         sel_x;
   logic [1:0]         sel_y;
   logic [3:0]         sel_idx;
   logic               sel_in_range;
   logic               move_ok;
   logic               legal_move;
   player_t            opponent;
   logic [SCORE_W-1:0] score0_inc;
   logic [SCORE_W-1:0] score1_inc;

   assign in_wait   = (state == S_WAIT_MOVE);
   assign timer_clr = (state == S_CLEAR) || (state == S_CHECK);

   ttt_move_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (timer_clr),
      .en     (in_wait),
      .expired(expired)
   );

   // Only the turn player's request is ever evaluated against the board.
   assign sel_req      = (turn_q == P1) ? p1_req : p0_req;
   assign sel_x        = (turn_q == P1) ? p1_x   : p0_x;
   assign sel_y        = (turn_q == P1) ? p1_y   : p0_y;
   assign sel_idx      = cell_idx(sel_x, sel_y);
   assign sel_in_range = (sel_x < 2'd3) && (sel_y < 2'd3);
   assign move_ok      = sel_in_range && !board[sel_idx];
   assign legal_move   = in_wait && sel_req && move_ok;
   assign opponent     = (turn_q == P0) ? P1 : P0;

   assign score0_inc = (score0_q == '1) ? score0_q : score0_q + SCORE_W'(1);
   assign score1_inc = (score1_q == '1) ? score1_q : score1_q + SCORE_W'(1);

   // Handshake is answered in the request cycle so the accepted move reaches
   // the engine one cycle later; suppressed while reset is asserted.
   always_comb begin
      p0_ack  = 1'b0;
      p0_nack = 1'b0;
      p1_ack  = 1'b0;
      p1_nack = 1'b0;
      if (!reset) begin
         if (in_wait) begin
            if (turn_q == P0) begin
               p0_ack  = p0_req && move_ok;
               p0_nack = p0_req && !move_ok;
               p1_nack = p1_req;
            end else begin
               p1_ack  = p1_req && move_ok;
               p1_nack = p1_req && !move_ok;
               p0_nack = p0_req;
            end
         end else if (state == S_MATCH_DONE) begin
            p0_nack = p0_req;
            p1_nack = p1_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         turn_q         <= PNONE;
         starter        <= P0;
         round_winner   <= PNONE;
         eng_player_q   <= PNONE;
         match_winner_q <= PNONE;
         board          <= '0;
         score0_q       <= '0;
         score1_q       <= '0;
         match_over     <= 1'b0;
         eng_reset      <= 1'b1;
         eng_enable     <= 1'b0;
         eng_x          <= 2'd0;
         eng_y          <= 2'd0;
      end else begin
         eng_enable <= 1'b0;
         eng_reset  <= 1'b0;
         case (state)
            S_IDLE: begin
               eng_reset <= 1'b1;
               if (start) begin
                  score0_q <= '0;
                  score1_q <= '0;
                  starter  <= P0;
                  state    <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               board  <= '0;
               turn_q <= starter;
               state  <= S_WAIT_MOVE;
            end
            S_WAIT_MOVE: begin
               // A legal move in the final timer cycle still counts.
               if (legal_move) begin
                  board        <= board | (CELLS'(1) << sel_idx);
                  eng_x        <= sel_x;
                  eng_y        <= sel_y;
                  eng_player_q <= turn_q;
                  eng_enable   <= 1'b1;
                  state        <= S_ISSUE;
               end else if (expired) begin
                  round_winner <= opponent;
                  turn_q       <= PNONE;
                  state        <= S_ROUND_END;
               end
            end
            S_ISSUE: begin
               state <= S_CHECK;
            end
            S_CHECK: begin
               if (eng_stop) begin
                  case (eng_winner)
                     2'd0:    round_winner <= P0;
                     2'd1:    round_winner <= P1;
                     default: round_winner <= PNONE;
                  endcase
                  turn_q <= PNONE;
                  state  <= S_ROUND_END;
               end else begin
                  turn_q <= opponent;
                  state  <= S_WAIT_MOVE;
               end
            end
            S_ROUND_END: begin
               if (round_winner == P0) score0_q <= score0_inc;
               if (round_winner == P1) score1_q <= score1_inc;
               if ((round_winner == P0) && (score0_inc == WIN_SCORE)) begin
                  match_over     <= 1'b1;
                  match_winner_q <= P0;
                  state          <= S_MATCH_DONE;
               end else if ((round_winner == P1) && (score1_inc == WIN_SCORE)) begin
                  match_over     <= 1'b1;
                  match_winner_q <= P1;
                  state          <= S_MATCH_DONE;
               end else begin
                  starter   <= (starter == P0) ? P1 : P0;
                  eng_reset <= 1'b1;
                  state     <= S_CLEAR;
               end
            end
            S_MATCH_DONE: begin
               if (start) begin
                  score0_q       <= '0;
                  score1_q       <= '0;
                  starter        <= P0;
                  match_over     <= 1'b0;
                  match_winner_q <= PNONE;
                  eng_reset      <= 1'b1;
                  state          <= S_CLEAR;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign turn         = turn_q;
   assign eng_player   = eng_player_q;
   assign match_winner = match_winner_q;
   assign score0       = score0_q;
   assign score1       = score1_q;

endmodule

// File: tb/tb_ttt_match_ctrl.sv
// Self-checking bench for ttt_match_ctrl with a small behavioural engine.
module tb_ttt_match_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       p0_req = 1'b0, p1_req = 1'b0;
   logic [1:0] p0_x = 2'd0, p0_y = 2'd0, p1_x = 2'd0, p1_y = 2'd0;
   logic       p0_ack, p0_nack, p1_ack, p1_nack;
   logic       eng_reset, eng_enable;
   logic [1:0] eng_x, eng_y, eng_player;
   logic [1:0] eng_winner = 2'd3;
   logic       eng_stop = 1'b0;
   logic [1:0] turn;
   logic [3:0] score0, score1;
   logic       match_over;
   logic [1:0] match_winner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ttt_match_ctrl #(
      .TIMEOUT_CYCLES(8),
      .ROUNDS_TO_WIN (2),
      .SCORE_W       (4)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .p0_req(p0_req), .p0_x(p0_x), .p0_y(p0_y),
      .p1_req(p1_req), .p1_x(p1_x), .p1_y(p1_y),
      .p0_ack(p0_ack), .p0_nack(p0_nack), .p1_ack(p1_ack), .p1_nack(p1_nack),
      .eng_reset(eng_reset), .eng_enable(eng_enable),
      .eng_x(eng_x), .eng_y(eng_y), .eng_player(eng_player),
      .eng_winner(eng_winner), .eng_stop(eng_stop),
      .turn(turn), .score0(score0), .score1(score1),
      .match_over(match_over), .match_winner(match_winner)
   );

   // Behavioural engine: registered result one edge after enable.
   logic [8:0] m0 = '0, m1 = '0;

   function automatic logic [8:0] cbit(input logic [1:0] x, input logic [1:0] y);
      logic [8:0] r;
      r = '0;
      if (x < 2'd3 && y < 2'd3) r[int'(y) * 3 + int'(x)] = 1'b1;
      return r;
   endfunction

   function automatic logic line3(input logic [8:0] m);
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   always @(posedge clk) begin
      if (eng_reset === 1'b1) begin
         m0 <= '0; m1 <= '0; eng_winner <= 2'd3; eng_stop <= 1'b0;
      end else if (eng_enable === 1'b1) begin
         if (eng_player == 2'd0) begin
            m0 <= m0 | cbit(eng_x, eng_y);
            if (line3(m0 | cbit(eng_x, eng_y))) begin
               eng_winner <= 2'd0; eng_stop <= 1'b1;
            end else if ((m0 | m1 | cbit(eng_x, eng_y)) == 9'h1ff) begin
               eng_winner <= 2'd3; eng_stop <= 1'b1;
            end
         end else begin
            m1 <= m1 | cbit(eng_x, eng_y);
            if (line3(m1 | cbit(eng_x, eng_y))) begin
               eng_winner <= 2'd1; eng_stop <= 1'b1;
            end else if ((m0 | m1 | cbit(eng_x, eng_y)) == 9'h1ff) begin
               eng_winner <= 2'd3; eng_stop <= 1'b1;
            end
         end
      end
   end

   typedef struct {
      int pl;
      int x;
      int y;
      int ack;
      int turn;
   } vec_t;

   vec_t vecs[23];

   task automatic set_vec(input int i, input int pl, input int x, input int y,
                          input int ack, input int t);
      vecs[i].pl = pl; vecs[i].x = x; vecs[i].y = y; vecs[i].ack = ack; vecs[i].turn = t;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive_req(input int pl, input int x, input int y, input logic v);
      if (pl == 0) begin
         p0_req = v; p0_x = 2'(x); p0_y = 2'(y);
      end else begin
         p1_req = v; p1_x = 2'(x); p1_y = 2'(y);
      end
   endtask

   task automatic wait_turn();
      int n = 0;
      while (turn == 2'd3 && n < 12) begin
         @(negedge clk);
         n++;
      end
      chk("turn_ready", int'(turn != 2'd3), 1);
   endtask

   task automatic apply(input int i);
      vec_t v;
      v = vecs[i];
      wait_turn();
      chk($sformatf("v%0d_turn", i), int'(turn), v.turn);
      drive_req(v.pl, v.x, v.y, 1'b1);
      #1;
      chk($sformatf("v%0d_ack", i), int'(v.pl == 0 ? p0_ack : p1_ack), v.ack);
      chk($sformatf("v%0d_nack", i), int'(v.pl == 0 ? p0_nack : p1_nack), 1 - v.ack);
      chk($sformatf("v%0d_other", i),
          int'(v.pl == 0 ? (p1_ack | p1_nack) : (p0_ack | p0_nack)), 0);
      chk($sformatf("v%0d_en_req", i), int'(eng_enable), 0);
      @(negedge clk);
      drive_req(v.pl, v.x, v.y, 1'b0);
      if (v.ack != 0) begin
         chk($sformatf("v%0d_en_issue", i), int'(eng_enable), 1);
         chk($sformatf("v%0d_eng_xy", i), int'(eng_x) * 4 + int'(eng_y), v.x * 4 + v.y);
         chk($sformatf("v%0d_eng_player", i), int'(eng_player), v.pl);
         @(negedge clk);
         chk($sformatf("v%0d_en_check", i), int'(eng_enable), 0);
         @(negedge clk);
      end else begin
         chk($sformatf("v%0d_en_nack", i), int'(eng_enable), 0);
      end
   endtask

   task automatic run(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) apply(i);
   endtask

   task automatic round_end_check(input string name, input int s0, input int s1, input int t);
      int pulses = 0;
      int n = 0;
      while (turn == 2'd3 && n < 12) begin
         if (eng_reset) pulses++;
         @(negedge clk);
         n++;
      end
      chk({name, "_reset_pulse"}, pulses, 1);
      chk({name, "_score0"}, int'(score0), s0);
      chk({name, "_score1"}, int'(score1), s1);
      chk({name, "_turn"}, int'(turn), t);
   endtask

   initial begin
      // round 1, starter P0 (index 0 used only when replaying the round)
      set_vec(0, 0, 0, 0, 1, 0);
      set_vec(1, 1, 1, 0, 1, 1);
      set_vec(2, 0, 0, 0, 0, 0);
      set_vec(3, 0, 3, 0, 0, 0);
      set_vec(4, 0, 0, 3, 0, 0);
      set_vec(5, 0, 0, 1, 1, 0);
      set_vec(6, 1, 1, 1, 1, 1);
      set_vec(7, 0, 0, 2, 1, 0);
      // round 2, starter P1, full-board draw
      set_vec(8,  1, 0, 0, 1, 1);
      set_vec(9,  0, 1, 0, 1, 0);
      set_vec(10, 1, 2, 0, 1, 1);
      set_vec(11, 0, 1, 1, 1, 0);
      set_vec(12, 1, 0, 1, 1, 1);
      set_vec(13, 0, 2, 1, 1, 0);
      set_vec(14, 1, 1, 2, 1, 1);
      set_vec(15, 0, 0, 2, 1, 0);
      set_vec(16, 1, 2, 2, 1, 1);
      // round 4, starter P1, P0 takes the top row
      set_vec(17, 1, 2, 2, 1, 1);
      set_vec(18, 0, 0, 0, 1, 0);
      set_vec(19, 1, 1, 1, 1, 1);
      set_vec(20, 0, 1, 0, 1, 0);
      set_vec(21, 1, 2, 1, 1, 1);
      set_vec(22, 0, 2, 0, 1, 0);

      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_turn", int'(turn), 3);
      chk("rst_score0", int'(score0), 0);
      chk("rst_score1", int'(score1), 0);
      chk("rst_match_over", int'(match_over), 0);
      chk("rst_match_winner", int'(match_winner), 3);
      chk("rst_eng_reset", int'(eng_reset), 1);
      chk("rst_eng_enable", int'(eng_enable), 0);
      chk("rst_handshake", int'(p0_ack | p0_nack | p1_ack | p1_nack), 0);
      @(negedge clk);
      chk("idle_eng_reset", int'(eng_reset), 1);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_turn();
      chk("r1_turn", int'(turn), 0);

      // wrong player held for several cycles
      for (int c = 0; c < 3; c++) begin
         drive_req(1, 0, 0, 1'b1);
         #1;
         chk($sformatf("wrong_p1_nack%0d", c), int'(p1_nack), 1);
         chk($sformatf("wrong_p1_ack%0d", c), int'(p1_ack), 0);
         chk($sformatf("wrong_en%0d", c), int'(eng_enable), 0);
         @(negedge clk);
      end
      drive_req(1, 0, 0, 1'b0);
      chk("wrong_turn_kept", int'(turn), 0);

      // simultaneous requests: turn player wins, other is rejected
      drive_req(0, 0, 0, 1'b1);
      drive_req(1, 2, 2, 1'b1);
      #1;
      chk("both_p0_ack", int'(p0_ack), 1);
      chk("both_p1_nack", int'(p1_nack), 1);
      @(negedge clk);
      drive_req(0, 0, 0, 1'b0);
      drive_req(1, 2, 2, 1'b0);
      chk("both_en", int'(eng_enable), 1);
      chk("both_eng_xy", int'(eng_x) * 4 + int'(eng_y), 0);
      chk("both_eng_player", int'(eng_player), 0);
      @(negedge clk);
      @(negedge clk);

      run(1, 7);
      round_end_check("r1", 1, 0, 1);

      run(8, 16);
      round_end_check("r2_draw", 1, 0, 0);

      // round 3: P0 idles (one illegal try) and forfeits
      for (int c = 1; c <= 8; c++) begin
         chk($sformatf("to_turn%0d", c), int'(turn), 0);
         if (c == 3) begin
            drive_req(0, 3, 0, 1'b1);
            #1;
            chk("to_illegal_nack", int'(p0_nack), 1);
         end
         @(negedge clk);
         drive_req(0, 3, 0, 1'b0);
      end
      chk("to_round_end", int'(turn), 3);
      chk("to_no_enable", int'(eng_enable), 0);
      round_end_check("r3_forfeit", 1, 1, 1);

      // round 4: legal move in the final timer cycle beats the timeout
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("late_turn%0d", c), int'(turn), 1);
         @(negedge clk);
      end
      run(17, 22);

      begin
         int n = 0;
         while (!match_over && n < 8) begin
            @(negedge clk);
            n++;
         end
      end
      chk("md_match_over", int'(match_over), 1);
      chk("md_match_winner", int'(match_winner), 0);
      chk("md_score0", int'(score0), 2);
      chk("md_score1", int'(score1), 1);
      chk("md_turn", int'(turn), 3);
      drive_req(0, 1, 1, 1'b1);
      drive_req(1, 2, 1, 1'b1);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("md_p0_nack%0d", c), int'(p0_nack), 1);
         chk($sformatf("md_p1_nack%0d", c), int'(p1_nack), 1);
         chk($sformatf("md_acks%0d", c), int'(p0_ack | p1_ack), 0);
         @(negedge clk);
         chk($sformatf("md_en%0d", c), int'(eng_enable), 0);
      end
      drive_req(0, 1, 1, 1'b0);
      drive_req(1, 2, 1, 1'b0);
      chk("md_still_over", int'(match_over), 1);

      // new match
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("m2_score0", int'(score0), 0);
      chk("m2_score1", int'(score1), 0);
      chk("m2_match_over", int'(match_over), 0);
      chk("m2_match_winner", int'(match_winner), 3);
      chk("m2_eng_reset", int'(eng_reset), 1);
      wait_turn();
      chk("m2_turn", int'(turn), 0);
      run(0, 7);
      round_end_check("m2r1", 1, 0, 1);

      // reset in the same cycle as a legal request
      drive_req(1, 2, 2, 1'b1);
      reset = 1'b1;
      #1;
      chk("rr_ack", int'(p1_ack), 0);
      chk("rr_nack", int'(p1_nack), 0);
      @(negedge clk);
      reset = 1'b0;
      chk("rr_turn", int'(turn), 3);
      chk("rr_score0", int'(score0), 0);
      chk("rr_score1", int'(score1), 0);
      chk("rr_eng_enable", int'(eng_enable), 0);
      chk("rr_eng_reset", int'(eng_reset), 1);
      chk("rr_match_over", int'(match_over), 0);
      #1;
      chk("rr_idle_handshake", int'(p1_ack | p1_nack), 0);
      @(negedge clk);
      drive_req(1, 2, 2, 1'b0);
      chk("rr_idle_no_enable", int'(eng_enable), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
